// File: rtl/uart_rx_fifo_if.sv
// Host-facing bundle of the UART receive FIFO: write strobe and data in,
// pop and overflow clear in, FWFT head, fill-level flags and count out.
interface uart_rx_fifo_if #(
    parameter int unsigned DBIT   = 8,
    parameter int unsigned ADDR_W = 4
) ();
    logic              rx_done_tick;
    logic [DBIT-1:0]   rx_dout;
    logic              rd;
    logic              clr_ovf;
    logic [DBIT-1:0]   r_data;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic [ADDR_W:0]   count;
    logic              overflow;

    modport master (
        output rx_done_tick, rx_dout, rd, clr_ovf,
        input  r_data, empty, full, almost_full, count, overflow
    );

    modport slave (
        input  rx_done_tick, rx_dout, rd, clr_ovf,
        output r_data, empty, full, almost_full, count, overflow
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte buffer behind the UART receiver, with
// registered fill flags and a sticky overflow flag for dropped bytes.
module uart_rx_fifo #(
    parameter int unsigned DBIT     = 8,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned AF_LEVEL = 12
) (
    input  logic           clk,
    input  logic           reset,
    uart_rx_fifo_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CW    = ADDR_W + 1;

    logic [DBIT-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_nxt;
    logic              empty_q;
    logic              full_q;
    logic              af_q;
    logic              ovf_q;
    logic              wr_en;
    logic              rd_en;
    logic              drop;

    // A write into a full buffer is still accepted when the head is popped in the same cycle.
    always_comb begin
        rd_en     = bus.rd && !empty_q;
        wr_en     = bus.rx_done_tick && (!full_q || bus.rd);
        drop      = bus.rx_done_tick && full_q && !bus.rd;
        count_nxt = count_q;
        if (wr_en && !rd_en) begin
            count_nxt = count_q + CW'(1);
        end else if (rd_en && !wr_en) begin
            count_nxt = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem[wr_ptr] <= bus.rx_dout;
        end
    end

    // Flags are computed from the next count so they track the registered count exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            count_q <= count_nxt;
            empty_q <= (count_nxt == CW'(0));
            full_q  <= (count_nxt == CW'(DEPTH));
            af_q    <= (count_nxt >= CW'(AF_LEVEL));
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (bus.clr_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign bus.r_data      = mem[rd_ptr];
    assign bus.empty       = empty_q;
    assign bus.full        = full_q;
    assign bus.almost_full = af_q;
    assign bus.count       = count_q;
    assign bus.overflow    = ovf_q;
endmodule
